// File: rtl/mem_sub_sequencer.sv
// Fetch/decode/execute sequencer for the PC/ROM/IR/RAM/RDR memory subsystem.
// Stalls on the I/O port address until port_ready_i arrives, and faults if it does not arrive in time.
module mem_sub_sequencer #(
  parameter logic [6:0]  PORT_ADDR  = 7'd67,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned ICNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic [3:0]            opcode_i,
  input  logic                  i_flag_i,
  input  logic [6:0]            addr_out_i,
  input  logic                  port_ready_i,
  output logic                  rom_cs_o,
  output logic                  rom_oe_o,
  output logic                  ram_cs_o,
  output logic                  ram_oe_o,
  output logic                  pc_en_o,
  output logic                  load_en_o,
  output logic                  ir_en_o,
  output logic                  rdr_en_o,
  output logic                  alu_en_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  fault_o,
  output logic [ICNT_WIDTH-1:0] icnt_o
);

  // state  | meaning
  // IDLE   | stopped at an instruction boundary, waiting for run_i
  // FETCH  | ROM read, IR capture
  // DECODE | opcode dispatch, PC increment
  // PWAIT  | stalled on the I/O port, timeout running
  // MEMRD  | RAM read into RDR
  // MEMWR  | RAM write
  // EXEC   | PC load (JUMP) or ALU commit
  // RETIRE | instruction count, then FETCH or IDLE
  // HALT   | sticky until reset
  // FAULT  | sticky until reset (port timeout or illegal opcode)
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PWAIT, S_MEMRD,
    S_MEMWR, S_EXEC, S_RETIRE, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_JUMP  = 4'd3;
  localparam logic [3:0] OP_ALU   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd15;
  localparam int         TW       = $clog2(TIMEOUT) + 1;

  state_t          state_q, state_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            store_q, store_d;
  logic            jump_q, jump_d;
  logic            is_port;
  logic            rom_cs_q, rom_oe_q, ram_cs_q, ram_oe_q;
  logic            load_en_q, ir_en_q, rdr_en_q, alu_en_q;
  logic            busy_q, halted_q, fault_q;
  logic [ICNT_WIDTH-1:0] icnt_q;

  assign is_port = (addr_out_i == PORT_ADDR);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    store_d = store_q;
    jump_d  = jump_q;
    case (state_q)
      S_IDLE:   if (run_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        store_d = (opcode_i == OP_STORE);
        jump_d  = (opcode_i == OP_JUMP);
        wait_d  = TW'(TIMEOUT - 1);
        case (opcode_i)
          OP_NOP:   state_d = S_RETIRE;
          OP_STORE: state_d = is_port ? S_PWAIT : S_MEMWR;
          OP_LOAD:  state_d = i_flag_i ? S_EXEC : (is_port ? S_PWAIT : S_MEMRD);
          OP_JUMP,
          OP_ALU:   state_d = S_EXEC;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FAULT;
        endcase
      end
      // Ready is tested before the terminal count, so a late ready still wins.
      S_PWAIT: begin
        if (port_ready_i)        state_d = store_q ? S_MEMWR : S_MEMRD;
        else if (wait_q == '0)   state_d = S_FAULT;
        else                     wait_d  = wait_q - 1'b1;
      end
      S_MEMRD:  state_d = S_EXEC;
      S_MEMWR:  state_d = S_RETIRE;
      S_EXEC:   state_d = S_RETIRE;
      S_RETIRE: state_d = run_i ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      store_q   <= 1'b0;
      jump_q    <= 1'b0;
      rom_cs_q  <= 1'b1;
      rom_oe_q  <= 1'b1;
      ram_cs_q  <= 1'b1;
      ram_oe_q  <= 1'b1;
      load_en_q <= 1'b0;
      ir_en_q   <= 1'b0;
      rdr_en_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      store_q   <= store_d;
      jump_q    <= jump_d;
      rom_cs_q  <= (state_d != S_FETCH);
      rom_oe_q  <= (state_d != S_FETCH);
      ram_cs_q  <= !(state_d == S_MEMRD || state_d == S_MEMWR);
      ram_oe_q  <= (state_d != S_MEMWR);
      load_en_q <= (state_d == S_EXEC) && jump_d;
      ir_en_q   <= (state_d == S_FETCH);
      rdr_en_q  <= (state_d == S_MEMRD);
      alu_en_q  <= (state_d == S_EXEC) && !jump_d;
      busy_q    <= !(state_d == S_IDLE || state_d == S_HALT || state_d == S_FAULT);
      halted_q  <= (state_d == S_HALT);
      fault_q   <= (state_d == S_FAULT);
      if (state_q == S_RETIRE) icnt_q <= icnt_q + 1'b1;
    end
  end

  // The opcode is only valid once the IR has captured it, so the PC strobe follows DECODE directly.
  assign pc_en_o   = (state_q == S_DECODE) && (opcode_i != OP_JUMP) && (opcode_i != OP_HALT);
  assign rom_cs_o  = rom_cs_q;
  assign rom_oe_o  = rom_oe_q;
  assign ram_cs_o  = ram_cs_q;
  assign ram_oe_o  = ram_oe_q;
  assign load_en_o = load_en_q;
  assign ir_en_o   = ir_en_q;
  assign rdr_en_o  = rdr_en_q;
  assign alu_en_o  = alu_en_q;
  assign busy_o    = busy_q;
  assign halted_o  = halted_q;
  assign fault_o   = fault_q;
  assign icnt_o    = icnt_q;

endmodule

// File: tb/tb_mem_sub_sequencer.sv
// Randomized instruction stream against a latency/strobe-count reference model.
// Driver pushes expected per-instruction outcomes; a monitor pops them on retire/halt/fault.
module tb_mem_sub_sequencer;
  localparam int TIMEOUT = 15;

  logic        clk_i = 1'b0, rst_ni = 1'b0, run_i = 1'b0;
  logic [3:0]  opcode_i = '0;
  logic        i_flag_i = 1'b0, port_ready_i = 1'b0;
  logic [6:0]  addr_out_i = '0;
  logic        rom_cs_o, rom_oe_o, ram_cs_o, ram_oe_o, pc_en_o, load_en_o, ir_en_o;
  logic        rdr_en_o, alu_en_o, busy_o, halted_o, fault_o;
  logic [15:0] icnt_o;

  mem_sub_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .opcode_i(opcode_i),
    .i_flag_i(i_flag_i), .addr_out_i(addr_out_i), .port_ready_i(port_ready_i),
    .rom_cs_o(rom_cs_o), .rom_oe_o(rom_oe_o), .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o),
    .pc_en_o(pc_en_o), .load_en_o(load_en_o), .ir_en_o(ir_en_o), .rdr_en_o(rdr_en_o),
    .alu_en_o(alu_en_o), .busy_o(busy_o), .halted_o(halted_o), .fault_o(fault_o),
    .icnt_o(icnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int checks = 0, errors = 0;

  // kind: 0 retire, 1 halt, 2 fault; cycles measured from the FETCH cycle to the visible outcome
  typedef struct {
    int kind; int cycles;
    int pc; int ld; int rdr; int alu; int ramrd; int ramwr; int romrd;
    logic [15:0] icnt;
  } exp_t;

  exp_t        q[$];
  exp_t        e, m;
  logic [15:0] m_icnt = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic mon_en = 1'b0, active = 1'b0, prev_h = 1'b0, prev_f = 1'b0;
  logic [15:0] last_icnt = '0;
  int start_cyc = 0;
  int c_pc, c_ld, c_rdr, c_alu, c_rd, c_wr, c_rom, c_nbusy, c_bad;

  always @(negedge clk_i) begin
    if (!rst_ni || !mon_en) begin
      active = 1'b0; last_icnt = icnt_o; prev_h = halted_o; prev_f = fault_o;
    end else begin
      if (icnt_o !== last_icnt || (halted_o && !prev_h) || (fault_o && !prev_f)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: icnt=%0d halted=%0d fault=%0d", icnt_o, halted_o, fault_o);
        end else begin
          m = q.pop_front();
          chk("outcome_kind", fault_o ? 2 : (halted_o ? 1 : 0), m.kind);
          chk("latency", cyc - start_cyc, m.cycles);
          chk("pc_en_pulses", c_pc, m.pc);
          chk("load_en_pulses", c_ld, m.ld);
          chk("rdr_en_pulses", c_rdr, m.rdr);
          chk("alu_en_pulses", c_alu, m.alu);
          chk("ram_read_cycles", c_rd, m.ramrd);
          chk("ram_write_cycles", c_wr, m.ramwr);
          chk("rom_read_cycles", c_rom, m.romrd);
          chk("busy_low_in_instr", c_nbusy, 0);
          chk("exclusive_strobes", c_bad, 0);
          chk("icnt", icnt_o, m.icnt);
          if (m.kind != 0) chk("busy_after_stop", busy_o, 0);
        end
        active = 1'b0;
      end
      last_icnt = icnt_o; prev_h = halted_o; prev_f = fault_o;
      if (ir_en_o) begin
        active = 1'b1; start_cyc = cyc;
        c_pc = 0; c_ld = 0; c_rdr = 0; c_alu = 0; c_rd = 0; c_wr = 0; c_rom = 0; c_nbusy = 0; c_bad = 0;
      end
      if (active) begin
        c_pc    += int'(pc_en_o);
        c_ld    += int'(load_en_o);
        c_rdr   += int'(rdr_en_o);
        c_alu   += int'(alu_en_o);
        c_rd    += int'(!ram_cs_o && ram_oe_o);
        c_wr    += int'(!ram_cs_o && !ram_oe_o);
        c_rom   += int'(!rom_cs_o && !rom_oe_o);
        c_nbusy += int'(!busy_o);
        c_bad   += int'((pc_en_o && load_en_o) || (!ram_cs_o && !rom_cs_o));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    @(posedge clk_i); #1 rst_ni = 1'b0; #1;
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_halted", halted_o, 0);
    chk("async_rst_fault", fault_o, 0);
    chk("async_rst_rom_cs", rom_cs_o, 1);
    chk("async_rst_ram_cs", ram_cs_o, 1);
    chk("async_rst_icnt", icnt_o, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    m_icnt = '0; port_ready_i = 1'b0; run_i = 1'b1;
    @(posedge clk_i); #1 rst_ni = 1'b1;
  endtask

  int  t, n_wait, r;
  logic port, drop;

  initial begin
    run_i = 1'b1; rst_ni = 1'b0;
    #12;
    chk("rst_rom_cs", rom_cs_o, 1); chk("rst_rom_oe", rom_oe_o, 1);
    chk("rst_ram_cs", ram_cs_o, 1); chk("rst_ram_oe", ram_oe_o, 1);
    chk("rst_ir_en", ir_en_o, 0);   chk("rst_busy", busy_o, 0);
    chk("rst_icnt", icnt_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1; mon_en = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0); chk("idle_ir_en", ir_en_o, 0);
    @(negedge clk_i);
    chk("fetch_ir_en", ir_en_o, 1); chk("fetch_rom_cs", rom_cs_o, 0); chk("fetch_rom_oe", rom_oe_o, 0);

    for (int n = 0; n < 400; n++) begin
      t = 0;
      while (!ir_en_o && t < 60) begin @(negedge clk_i); t++; end
      if (!ir_en_o) begin
        checks++; errors++;
        $display("FAIL fetch_timeout: ir_en=%0d expected 1 within 60 cycles", ir_en_o);
        break;
      end
      port_ready_i = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 3)      opcode_i = 4'd15;
      else if (r < 6) opcode_i = 4'(5 + $urandom_range(0, 9));
      else            opcode_i = 4'($urandom_range(0, 4));
      i_flag_i   = 1'($urandom_range(0, 1));
      port       = ((opcode_i == 4'd1) || (opcode_i == 4'd2 && !i_flag_i)) && ($urandom_range(0, 2) == 0);
      addr_out_i = 7'($urandom_range(0, 127));
      if (port) addr_out_i = 7'd67;
      else if ((opcode_i == 4'd1) || (opcode_i == 4'd2 && !i_flag_i)) begin
        if (addr_out_i == 7'd67) addr_out_i = 7'd66;
      end else if ($urandom_range(0, 1) == 0) addr_out_i = 7'd67;
      n_wait = ($urandom_range(0, 3) == 0) ? 13 + $urandom_range(0, 3) : $urandom_range(0, 5);

      e.kind = 0; e.pc = 1; e.ld = 0; e.rdr = 0; e.alu = 0; e.ramrd = 0; e.ramwr = 0; e.romrd = 1;
      case (opcode_i)
        4'd0: e.cycles = 3;
        4'd1: begin e.cycles = 4; e.ramwr = 1; end
        4'd2: if (i_flag_i) begin e.cycles = 4; e.alu = 1; end
              else begin e.cycles = 5; e.rdr = 1; e.ramrd = 1; e.alu = 1; end
        4'd3: begin e.cycles = 4; e.pc = 0; e.ld = 1; end
        4'd4: begin e.cycles = 4; e.alu = 1; end
        4'd15: begin e.kind = 1; e.cycles = 2; e.pc = 0; end
        default: begin e.kind = 2; e.cycles = 2; end
      endcase
      if (port) begin
        if (n_wait < TIMEOUT) e.cycles += n_wait + 1;
        else begin
          e.kind = 2; e.cycles = 2 + TIMEOUT;
          e.rdr = 0; e.ramrd = 0; e.ramwr = 0; e.alu = 0;
        end
      end
      if (e.kind == 0) m_icnt = m_icnt + 16'd1;
      e.icnt = m_icnt;
      q.push_back(e);

      drop = ($urandom_range(0, 7) == 0);
      if (drop) run_i = 1'b0;
      if (port) begin
        repeat (2 + n_wait) @(negedge clk_i);
        if (n_wait < TIMEOUT) port_ready_i = 1'b1;
      end

      if (e.kind != 0) begin
        t = 0;
        while (!(halted_o || fault_o) && t < 40) begin @(negedge clk_i); t++; end
        repeat (4) @(negedge clk_i);
        chk("sticky_halted", halted_o, (e.kind == 1) ? 1 : 0);
        chk("sticky_fault", fault_o, (e.kind == 2) ? 1 : 0);
        chk("sticky_busy", busy_o, 0);
        chk("sticky_icnt", icnt_o, m_icnt);
        do_reset();
      end else if (drop) begin
        t = 0;
        while (busy_o && t < 40) begin @(negedge clk_i); t++; end
        repeat (3) @(negedge clk_i);
        chk("run_low_stays_idle", busy_o, 0);
        chk("run_low_no_fetch", ir_en_o, 0);
        run_i = 1'b1;
      end
      @(negedge clk_i);
    end

    // Let the last outcome drain, then pull reset in the middle of a RAM read.
    run_i = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 60) begin @(negedge clk_i); t++; end
    chk("final_queue_empty", q.size(), 0);
    mon_en = 1'b0;
    t = 0;
    while (!ir_en_o && t < 60) begin @(negedge clk_i); t++; end
    chk("directed_fetch_seen", ir_en_o, 1);
    opcode_i = 4'd2; i_flag_i = 1'b0; addr_out_i = 7'd5; port_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("memrd_rdr_en", rdr_en_o, 1);
    chk("memrd_ram_cs", ram_cs_o, 0);
    chk("memrd_ram_oe", ram_oe_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midinstr_rst_rdr_en", rdr_en_o, 0);
    chk("midinstr_rst_ram_cs", ram_cs_o, 1);
    chk("midinstr_rst_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
